// File: rtl/display_scan_controller_if.sv
// Time inputs, mode controls and scanned digit outputs of the display scan controller.
interface display_scan_controller_if;
    logic [4:0] hours;
    logic [5:0] minutes;
    logic [1:0] blink_sel;
    logic       display_en;
    logic [1:0] digit_sel;
    logic [3:0] hour_tens;
    logic [3:0] hour_ones;
    logic [3:0] min_tens;
    logic [3:0] min_ones;
    logic       frame_tick;

    modport master (
        output hours, minutes, blink_sel, display_en,
        input  digit_sel, hour_tens, hour_ones, min_tens, min_ones, frame_tick
    );

    modport slave (
        input  hours, minutes, blink_sel, display_en,
        output digit_sel, hour_tens, hour_ones, min_tens, min_ones, frame_tick
    );
endinterface

// File: rtl/display_scan_controller.sv
// Four-digit scan controller: snapshots hours/minutes once per frame into BCD digit registers.
// Optional macro LEADING_ZERO_BLANK_EN blanks a zero hour-tens digit.
module display_scan_controller #(
    parameter int unsigned REFRESH_DIV  = 100000,
    parameter int unsigned BLINK_FRAMES = 125
) (
    input logic clk,
    input logic rst,
    display_scan_controller_if.slave scan
);
    localparam int unsigned   PW         = $clog2(REFRESH_DIV);
    localparam int unsigned   FW         = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
    localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);
    localparam logic [3:0]    BLANK      = 4'hF;

    logic [PW-1:0] presc;
    logic [1:0]    digit_sel;
    logic [FW-1:0] frame_cnt;
    logic          blink_phase;
    logic [3:0]    hour_tens, hour_ones, min_tens, min_ones;
    logic          frame_tick;

    logic          slot_tick, frame_end, next_phase;
    logic [3:0]    h_tens, h_ones, m_tens, m_ones;
    logic          invalid, blank_all, blank_hours, blank_minutes;

    // Repeated compare/subtract; six passes cover any 6-bit value.
    function automatic logic [7:0] to_bcd(input logic [5:0] value);
        logic [5:0] rem;
        logic [3:0] tens;
        rem  = value;
        tens = '0;
        for (int unsigned i = 0; i < 6; i++) begin
            if (rem >= 6'd10) begin
                rem  = rem - 6'd10;
                tens = tens + 4'd1;
            end
        end
        return {tens, rem[3:0]};
    endfunction

    assign slot_tick = (presc == PRESC_LAST);
    assign frame_end = slot_tick && (digit_sel == 2'b11);

    always_comb begin
        {h_tens, h_ones} = to_bcd({1'b0, scan.hours});
        {m_tens, m_ones} = to_bcd(scan.minutes);
        // The load on the wrapping boundary already uses the toggled phase.
        next_phase    = (frame_cnt == FRAME_LAST) ? ~blink_phase : blink_phase;
        invalid       = (scan.hours > 5'd23) || (scan.minutes > 6'd59);
        blank_all     = !scan.display_en || invalid;
        blank_hours   = blank_all || (next_phase && scan.blink_sel[0]);
        blank_minutes = blank_all || (next_phase && scan.blink_sel[1]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc       <= '0;
            digit_sel   <= '0;
            frame_cnt   <= '0;
            blink_phase <= 1'b0;
            hour_tens   <= '0;
            hour_ones   <= '0;
            min_tens    <= '0;
            min_ones    <= '0;
            frame_tick  <= 1'b0;
        end else begin
            frame_tick <= 1'b0;
            if (slot_tick) begin
                presc     <= '0;
                digit_sel <= digit_sel + 2'd1;
            end else begin
                presc <= presc + 1'b1;
            end

            if (frame_end) begin
                frame_tick  <= 1'b1;
                frame_cnt   <= (frame_cnt == FRAME_LAST) ? '0 : frame_cnt + 1'b1;
                blink_phase <= next_phase;
`ifdef LEADING_ZERO_BLANK_EN
                hour_tens   <= (blank_hours || (h_tens == 4'd0)) ? BLANK : h_tens;
`else
                hour_tens   <= blank_hours ? BLANK : h_tens;
`endif
                hour_ones   <= blank_hours ? BLANK : h_ones;
                min_tens    <= blank_minutes ? BLANK : m_tens;
                min_ones    <= blank_minutes ? BLANK : m_ones;
            end
        end
    end

    assign scan.digit_sel  = digit_sel;
    assign scan.hour_tens  = hour_tens;
    assign scan.hour_ones  = hour_ones;
    assign scan.min_tens   = min_tens;
    assign scan.min_ones   = min_ones;
    assign scan.frame_tick = frame_tick;
endmodule

// File: tb/tb_display_scan_controller.sv
// Bench for display_scan_controller with REFRESH_DIV=4, BLINK_FRAMES=2 (16-cycle frames).
module tb_display_scan_controller;
    logic clk;
    logic rst;

    display_scan_controller_if scan ();

    display_scan_controller #(
        .REFRESH_DIV (4),
        .BLINK_FRAMES(2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .scan(scan)
    );

    typedef struct {
        logic [4:0]  hours;
        logic [5:0]  minutes;
        logic [1:0]  blink_sel;
        logic        display_en;
        logic [15:0] exp;
    } vec_t;

    vec_t        vecs[$];
    logic [15:0] sb[$];
    int          vectors = 0;
    int          miscompares = 0;
    int          gap = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s got %h want %h at %0t", name, got, want, $time);
        end
    endtask

    // Expected frame contents; a zero hour-tens digit is blanked when the option is built in.
    task automatic expect_frame(input logic [15:0] exp);
        logic [15:0] e;
        e = exp;
`ifdef LEADING_ZERO_BLANK_EN
        if (e[15:12] == 4'h0) e[15:12] = 4'hF;
`endif
        sb.push_back(e);
    endtask

    task automatic add(input logic [4:0] h, input logic [5:0] m, input logic [1:0] bs,
                       input logic en, input logic [15:0] exp);
        vec_t v;
        v.hours = h; v.minutes = m; v.blink_sel = bs; v.display_en = en; v.exp = exp;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic [4:0] h, input logic [5:0] m, input logic [1:0] bs, input logic en);
        scan.hours      = h;
        scan.minutes    = m;
        scan.blink_sel  = bs;
        scan.display_en = en;
    endtask

    task automatic wait_tick();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (scan.frame_tick) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            vectors++;
            miscompares++;
            $display("FAIL tick_timeout got none want frame_tick within 40 cycles");
        end
    endtask

    // Scoreboard: every frame_tick pops one expected frame and checks frame spacing.
    always @(negedge clk) begin
        logic [15:0] e;
        if (rst) begin
            gap = 0;
        end else if (scan.frame_tick) begin
            check("frame_gap", gap, 16);
            check("tick_digit_sel", {30'd0, scan.digit_sel}, 0);
            if (sb.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_frame got %h want no frame",
                         {scan.hour_tens, scan.hour_ones, scan.min_tens, scan.min_ones});
            end else begin
                e = sb.pop_front();
                check("frame_digits", {16'd0, scan.hour_tens, scan.hour_ones, scan.min_tens, scan.min_ones}, {16'd0, e});
            end
            gap = 1;
        end else begin
            gap++;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Applied one per frame from boundary 4; blink phase is 1 on boundaries 6,7,10,11,14,15,18.
        add(5'd24, 6'd10, 2'b00, 1'b1, 16'hFFFF);
        add(5'd23, 6'd59, 2'b00, 1'b1, 16'h2359);
        add(5'd8,  6'd30, 2'b10, 1'b1, 16'h08FF);
        add(5'd8,  6'd30, 2'b10, 1'b1, 16'h08FF);
        add(5'd8,  6'd30, 2'b10, 1'b1, 16'h0830);
        add(5'd8,  6'd30, 2'b11, 1'b1, 16'h0830);
        add(5'd8,  6'd30, 2'b11, 1'b1, 16'hFFFF);
        add(5'd8,  6'd30, 2'b01, 1'b1, 16'hFF30);
        add(5'd12, 6'd34, 2'b01, 1'b0, 16'hFFFF);
        add(5'd12, 6'd34, 2'b01, 1'b0, 16'hFFFF);
        add(5'd12, 6'd34, 2'b00, 1'b1, 16'h1234);
        add(5'd9,  6'd5,  2'b01, 1'b1, 16'hFF05);
        add(5'd9,  6'd5,  2'b01, 1'b1, 16'h0905);
        add(5'd5,  6'd60, 2'b00, 1'b1, 16'hFFFF);
        add(5'd0,  6'd0,  2'b10, 1'b1, 16'h00FF);

        rst = 1'b1;
        drive(5'd0, 6'd0, 2'b00, 1'b1);
        expect_frame(16'h0000);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        for (int k = 0; k < 20; k++) begin
            logic [1:0] want_sel;
            @(negedge clk);
            want_sel = 2'((k / 4) % 4);
            check("scan_digit_sel", {30'd0, scan.digit_sel}, {30'd0, want_sel});
            check("scan_frame_tick", {31'd0, scan.frame_tick}, (k == 16) ? 32'd1 : 32'd0);
            if (k == 0)
                check("reset_digits", {16'd0, scan.hour_tens, scan.hour_ones, scan.min_tens, scan.min_ones}, 0);
        end

        drive(5'd13, 6'd47, 2'b00, 1'b1);
        expect_frame(16'h1347);
        wait_tick();
        repeat (8) @(negedge clk);
        drive(5'd14, 6'd48, 2'b00, 1'b1);
        expect_frame(16'h1448);
        repeat (7) @(negedge clk);
        check("midframe_hold", {16'd0, scan.hour_tens, scan.hour_ones, scan.min_tens, scan.min_ones}, 32'h1347);
        wait_tick();

        foreach (vecs[i]) begin
            drive(vecs[i].hours, vecs[i].minutes, vecs[i].blink_sel, vecs[i].display_en);
            expect_frame(vecs[i].exp);
            wait_tick();
        end

        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        drive(5'd7, 6'd5, 2'b00, 1'b1);
        expect_frame(16'h0705);
        @(negedge clk);
        check("midreset_digit_sel", {30'd0, scan.digit_sel}, 0);
        check("midreset_digits", {16'd0, scan.hour_tens, scan.hour_ones, scan.min_tens, scan.min_ones}, 0);
        check("midreset_frame_tick", {31'd0, scan.frame_tick}, 0);
        wait_tick();
        @(negedge clk);
        check("scoreboard_drained", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
